// File: rtl/axil_multi_adder.sv
// AXI4-Lite slave exposing NUM_CHANNELS add/sub/accumulate engines, one 16-byte register window each.
// Writing OPB launches a one-cycle registered compute; read and write channels run independently.
module axil_multi_adder #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int NUM_CHANNELS = 4,
    parameter int OPND_WIDTH   = 32
) (
    input  logic                    s1_axi_aclk,
    input  logic                    s1_axi_areset,
    input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
    input  logic                    s1_axi_awvalid,
    output logic                    s1_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
    input  logic                    s1_axi_wvalid,
    output logic                    s1_axi_wready,
    output logic [1:0]              s1_axi_bresp,
    output logic                    s1_axi_bvalid,
    input  logic                    s1_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s1_axi_araddr,
    input  logic                    s1_axi_arvalid,
    output logic                    s1_axi_arready,
    output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
    output logic [1:0]              s1_axi_rresp,
    output logic                    s1_axi_rvalid,
    input  logic                    s1_axi_rready
);
    localparam int         CH_W   = ADDR_WIDTH - 4;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } wstate_t;
    typedef enum logic { R_IDLE, R_DATA } rstate_t;

    wstate_t                 wstate_q;
    rstate_t                 rstate_q;
    logic                    aw_held_q, w_held_q;
    logic [ADDR_WIDTH-1:0]   awaddr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] wstrb_q;
    logic                    awready_q, wready_q, bvalid_q;
    logic [1:0]              bresp_q;
    logic                    arready_q, rvalid_q;
    logic [1:0]              rresp_q;
    logic [DATA_WIDTH-1:0]   rdata_q;

    logic [DATA_WIDTH-1:0] ch_opa  [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0] ch_opb  [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0] ch_res  [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0] ch_ctrl [NUM_CHANNELS];

    function automatic logic [DATA_WIDTH-1:0] strb_merge(
        input logic [DATA_WIDTH-1:0]   old_v,
        input logic [DATA_WIDTH-1:0]   new_v,
        input logic [DATA_WIDTH/8-1:0] strb
    );
        logic [DATA_WIDTH-1:0] r;
        r = old_v;
        for (int b = 0; b < DATA_WIDTH/8; b++) begin
            if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

    // Write decode works on the held address/data, so AW and W may arrive in any order.
    logic            wr_fire, wr_err, wr_en;
    logic [CH_W-1:0] wr_chan;
    logic [1:0]      wr_off;

    assign wr_chan = awaddr_q[ADDR_WIDTH-1:4];
    assign wr_off  = awaddr_q[3:2];
    assign wr_fire = (wstate_q == W_IDLE) && aw_held_q && w_held_q;
    assign wr_err  = (awaddr_q[1:0] != 2'b00)
                  || (32'(wr_chan) >= NUM_CHANNELS)
                  || (wr_off == 2'd2)
                  || ((wr_off == 2'd3) && wstrb_q[0] && (wdata_q[1:0] == 2'b11));
    assign wr_en   = wr_fire && !wr_err;

    always_ff @(posedge s1_axi_aclk) begin
        if (s1_axi_areset) begin
            wstate_q  <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    if (wr_fire) begin
                        aw_held_q <= 1'b0;
                        w_held_q  <= 1'b0;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= wr_err ? SLVERR : OKAY;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        wstate_q  <= W_RESP;
                    end else begin
                        if (s1_axi_awvalid && awready_q) begin
                            aw_held_q <= 1'b1;
                            awaddr_q  <= s1_axi_awaddr;
                        end
                        if (s1_axi_wvalid && wready_q) begin
                            w_held_q <= 1'b1;
                            wdata_q  <= s1_axi_wdata;
                            wstrb_q  <= s1_axi_wstrb;
                        end
                        awready_q <= !(aw_held_q || (s1_axi_awvalid && awready_q));
                        wready_q  <= !(w_held_q || (s1_axi_wvalid && wready_q));
                    end
                end
                W_RESP: begin
                    if (bvalid_q && s1_axi_bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        wstate_q  <= W_IDLE;
                    end
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
        logic [OPND_WIDTH-1:0] opa_q, opb_q, result_q;
        logic [1:0]            mode_q;
        logic                  done_q, carry_q, launch_q;
        logic                  sel;
        logic [DATA_WIDTH-1:0] merged_d;
        logic [OPND_WIDTH:0]   sum_d;

        assign sel      = wr_en && (wr_chan == CH_W'(gi));
        assign merged_d = strb_merge((wr_off == 2'd0) ? ch_opa[gi] : ch_opb[gi], wdata_q, wstrb_q);

        // The top bit of sum_d is carry for add/acc and borrow for sub.
        always_comb begin
            case (mode_q)
                2'b01:   sum_d = {1'b0, opa_q} - {1'b0, opb_q};
                2'b10:   sum_d = {1'b0, result_q} + {1'b0, opb_q};
                default: sum_d = {1'b0, opa_q} + {1'b0, opb_q};
            endcase
        end

        always_ff @(posedge s1_axi_aclk) begin
            if (s1_axi_areset) begin
                opa_q    <= '0;
                opb_q    <= '0;
                result_q <= '0;
                mode_q   <= 2'b00;
                done_q   <= 1'b0;
                carry_q  <= 1'b0;
                launch_q <= 1'b0;
            end else begin
                launch_q <= sel && (wr_off == 2'd1);
                if (launch_q) begin
                    result_q <= sum_d[OPND_WIDTH-1:0];
                    carry_q  <= sum_d[OPND_WIDTH];
                    done_q   <= 1'b1;
                end
                if (sel) begin
                    case (wr_off)
                        2'd0: begin
                            opa_q  <= merged_d[OPND_WIDTH-1:0];
                            done_q <= 1'b0;
                        end
                        2'd1: opb_q <= merged_d[OPND_WIDTH-1:0];
                        2'd3: begin
                            if (wstrb_q[0]) mode_q <= wdata_q[1:0];
                            done_q <= 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
        end

        assign ch_opa[gi]  = DATA_WIDTH'(opa_q);
        assign ch_opb[gi]  = DATA_WIDTH'(opb_q);
        assign ch_res[gi]  = DATA_WIDTH'(result_q);
        assign ch_ctrl[gi] = {22'd0, carry_q, done_q, 6'd0, mode_q};
    end

    logic [CH_W-1:0]       rd_chan;
    logic                  rd_err;
    logic [DATA_WIDTH-1:0] rd_val;

    assign rd_chan = s1_axi_araddr[ADDR_WIDTH-1:4];
    assign rd_err  = (s1_axi_araddr[1:0] != 2'b00) || (32'(rd_chan) >= NUM_CHANNELS);

    always_comb begin
        rd_val = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (rd_chan == CH_W'(c)) begin
                case (s1_axi_araddr[3:2])
                    2'd0:    rd_val = ch_opa[c];
                    2'd1:    rd_val = ch_opb[c];
                    2'd2:    rd_val = ch_res[c];
                    default: rd_val = ch_ctrl[c];
                endcase
            end
        end
    end

    // Read data is captured at address acceptance, so a same-cycle write or compute shows the old value.
    always_ff @(posedge s1_axi_aclk) begin
        if (s1_axi_areset) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= OKAY;
            rdata_q   <= '0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    if (s1_axi_arvalid && arready_q) begin
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rresp_q   <= rd_err ? SLVERR : OKAY;
                        rdata_q   <= rd_err ? '0 : rd_val;
                        rstate_q  <= R_DATA;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (rvalid_q && s1_axi_rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        rstate_q  <= R_IDLE;
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    assign s1_axi_awready = awready_q;
    assign s1_axi_wready  = wready_q;
    assign s1_axi_bvalid  = bvalid_q;
    assign s1_axi_bresp   = bresp_q;
    assign s1_axi_arready = arready_q;
    assign s1_axi_rvalid  = rvalid_q;
    assign s1_axi_rresp   = rresp_q;
    assign s1_axi_rdata   = rdata_q;
endmodule

// File: tb/tb_axil_multi_adder.sv
// Scoreboard bench for axil_multi_adder: expected responses are queued at issue and
// compared when the DUT presents B or R beats.
module tb_axil_multi_adder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [7:0]  araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    logic [1:0]  wr_exp_q[$];
    logic [33:0] rd_exp_q[$];

    axil_multi_adder #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_CHANNELS(4), .OPND_WIDTH(32)
    ) dut (
        .s1_axi_aclk(clk),       .s1_axi_areset(rst),
        .s1_axi_awaddr(awaddr),  .s1_axi_awvalid(awvalid), .s1_axi_awready(awready),
        .s1_axi_wdata(wdata),    .s1_axi_wstrb(wstrb),     .s1_axi_wvalid(wvalid),
        .s1_axi_wready(wready),  .s1_axi_bresp(bresp),     .s1_axi_bvalid(bvalid),
        .s1_axi_bready(bready),  .s1_axi_araddr(araddr),   .s1_axi_arvalid(arvalid),
        .s1_axi_arready(arready), .s1_axi_rdata(rdata),    .s1_axi_rresp(rresp),
        .s1_axi_rvalid(rvalid),  .s1_axi_rready(rready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input string tag, input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] exp_resp,
                             input int aw_delay = 0, input int b_delay = 0);
        int cyc;
        bit aw_done, w_done, a_rdy, w_rdy;
        logic [1:0] exp_r;
        wr_exp_q.push_back(exp_resp);
        awaddr = addr; wdata = data; wstrb = strb; wvalid = 1'b1;
        cyc = 0; aw_done = 0; w_done = 0;
        while (!(aw_done && w_done) && cyc < 100) begin
            if (cyc == aw_delay && !aw_done) awvalid = 1'b1;
            a_rdy = awready; w_rdy = wready;
            @(posedge clk); #1;
            if (awvalid && a_rdy) begin awvalid = 1'b0; aw_done = 1; end
            if (wvalid && w_rdy) begin wvalid = 1'b0; w_done = 1; end
            if (w_done && !aw_done && aw_delay > 0) chk({tag, "_wready_held"}, {31'd0, wready}, 32'd0);
            cyc++;
        end
        if (!(aw_done && w_done)) begin
            chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
            awvalid = 1'b0; wvalid = 1'b0;
        end
        cyc = 0;
        while (!bvalid && cyc < 100) begin @(posedge clk); #1; cyc++; end
        exp_r = wr_exp_q.pop_front();
        if (!bvalid) begin
            chk({tag, "_bvalid_timeout"}, 32'd0, 32'd1);
            return;
        end
        for (int i = 0; i < b_delay; i++) begin
            @(posedge clk); #1;
            chk({tag, "_bvalid_hold"}, {31'd0, bvalid}, 32'd1);
            chk({tag, "_bresp_hold"}, {30'd0, bresp}, {30'd0, exp_r});
        end
        chk({tag, "_bresp"}, {30'd0, bresp}, {30'd0, exp_r});
        $display("WR %s addr=0x%02h data=0x%08h strb=%b bresp=%0d", tag, addr, data, strb, bresp);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input string tag, input logic [7:0] addr,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp);
        int cyc;
        bit a_rdy, done;
        logic [33:0] e;
        rd_exp_q.push_back({exp_resp, exp_data});
        araddr = addr; arvalid = 1'b1;
        cyc = 0; done = 0;
        while (!done && cyc < 100) begin
            a_rdy = arready;
            @(posedge clk); #1;
            if (a_rdy) begin arvalid = 1'b0; done = 1; end
            cyc++;
        end
        arvalid = 1'b0;
        if (!done) chk({tag, "_ar_timeout"}, 32'd0, 32'd1);
        cyc = 0;
        while (!rvalid && cyc < 100) begin @(posedge clk); #1; cyc++; end
        e = rd_exp_q.pop_front();
        if (!rvalid) begin
            chk({tag, "_rvalid_timeout"}, 32'd0, 32'd1);
            return;
        end
        chk({tag, "_rdata"}, rdata, e[31:0]);
        chk({tag, "_rresp"}, {30'd0, rresp}, {30'd0, e[33:32]});
        $display("RD %s addr=0x%02h rdata=0x%08h rresp=%0d", tag, addr, rdata, rresp);
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    initial begin
        int cyc;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", {31'd0, awready}, 32'd0);
        chk("rst_wready",  {31'd0, wready},  32'd0);
        chk("rst_arready", {31'd0, arready}, 32'd0);
        chk("rst_valids",  {30'd0, bvalid, rvalid}, 32'd0);
        chk("rst_rdata",   rdata, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        axi_read("rst_ch0_result", 8'h08, 32'd0, 2'b00);

        // ch0 add
        axi_write("t1_opa", 8'h00, 32'd5, 4'hF, 2'b00);
        axi_write("t1_opb", 8'h04, 32'd7, 4'hF, 2'b00);
        axi_read("t1_result", 8'h08, 32'd12, 2'b00);
        axi_read("t1_ctrl", 8'h0C, 32'h100, 2'b00);

        // ch1 subtract with borrow, then OPA write clears DONE
        axi_write("t2_mode", 8'h1C, 32'd1, 4'hF, 2'b00);
        axi_write("t2_opa", 8'h10, 32'd3, 4'hF, 2'b00);
        axi_write("t2_opb", 8'h14, 32'd5, 4'hF, 2'b00);
        axi_read("t2_result", 8'h18, 32'hFFFF_FFFE, 2'b00);
        axi_read("t2_ctrl", 8'h1C, 32'h301, 2'b00);
        axi_write("t2_opa9", 8'h10, 32'd9, 4'hF, 2'b00);
        axi_read("t2_ctrl_clr", 8'h1C, 32'h201, 2'b00);
        axi_read("t2_result_keep", 8'h18, 32'hFFFF_FFFE, 2'b00);

        // ch2 accumulate, then add with carry-out
        axi_write("t3_mode", 8'h2C, 32'd2, 4'hF, 2'b00);
        for (int i = 0; i < 3; i++) axi_write("t3_acc", 8'h24, 32'd10, 4'hF, 2'b00);
        axi_read("t3_acc_result", 8'h28, 32'd30, 2'b00);
        axi_read("t3_acc_ctrl", 8'h2C, 32'h102, 2'b00);
        axi_write("t3_opa", 8'h20, 32'hFFFF_FFFF, 4'hF, 2'b00);
        axi_write("t3_mode0", 8'h2C, 32'd0, 4'hF, 2'b00);
        axi_write("t3_opb", 8'h24, 32'd1, 4'hF, 2'b00);
        axi_read("t3_wrap_result", 8'h28, 32'd0, 2'b00);
        axi_read("t3_wrap_ctrl", 8'h2C, 32'h300, 2'b00);

        // ch3: W leads AW by 3 cycles, B stalled 4 cycles; acc must fire once
        axi_write("t4_mode", 8'h3C, 32'd2, 4'hF, 2'b00);
        axi_write("t4_opb", 8'h34, 32'd6, 4'hF, 2'b00, 3, 4);
        axi_read("t4_result", 8'h38, 32'd6, 2'b00);
        axi_read("t4_ctrl", 8'h3C, 32'h102, 2'b00);

        // error decode
        axi_write("t5_ch4", 8'h44, 32'd1, 4'hF, 2'b10);
        axi_write("t5_result_wr", 8'h08, 32'd99, 4'hF, 2'b10);
        axi_write("t5_mode3", 8'h0C, 32'd3, 4'hF, 2'b10);
        axi_write("t5_unaligned", 8'h01, 32'd77, 4'hF, 2'b10);
        axi_read("t5_rd_unaligned", 8'h02, 32'd0, 2'b10);
        axi_read("t5_rd_ch4", 8'h40, 32'd0, 2'b10);
        axi_read("t5_ch0_opa", 8'h00, 32'd5, 2'b00);
        axi_read("t5_ch0_result", 8'h08, 32'd12, 2'b00);
        axi_read("t5_ch0_ctrl", 8'h0C, 32'h100, 2'b00);

        // byte strobe into OPA of ch3
        axi_write("t6_strb", 8'h30, 32'hAABB_CCDD, 4'b0001, 2'b00);
        axi_read("t6_opa", 8'h30, 32'h0000_00DD, 2'b00);
        axi_read("t6_ctrl", 8'h3C, 32'h002, 2'b00);

        // reset while a B response is pending
        awaddr = 8'h00; wdata = 32'h1234; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        cyc = 0;
        while (!bvalid && cyc < 10) begin @(posedge clk); #1; cyc++; end
        chk("t6_bvalid_pre", {31'd0, bvalid}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t6_bvalid_rst", {31'd0, bvalid}, 32'd0);
        chk("t6_awready_rst", {31'd0, awready}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("t6_bvalid_after", {31'd0, bvalid}, 32'd0);
        axi_read("t6_ch0_opa", 8'h00, 32'd0, 2'b00);
        axi_read("t6_ch0_result", 8'h08, 32'd0, 2'b00);
        axi_read("t6_ch1_ctrl", 8'h1C, 32'd0, 2'b00);
        axi_read("t6_ch2_result", 8'h28, 32'd0, 2'b00);
        axi_read("t6_ch3_opa", 8'h30, 32'd0, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
